// File: rtl/cyt_mux_pkg.sv
// Shared helpers for the tid-stamping stream mux: tid mapping,
// channel-index width and elaboration-time parameter legality.
package cyt_mux_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    localparam int MAX_CH = 16;

    function automatic int ch_bits(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int unsigned tid_of(input int base, input int ch);
        return int'(base + ch);
    endfunction

    function automatic bit params_ok(
        input int n_ch,
        input int tid_bits,
        input int tid_base
    );
        longint lim;
        if (n_ch < 1 || n_ch > MAX_CH) return 1'b0;
        if (tid_bits < 1 || tid_bits > 31) return 1'b0;
        if (tid_base < 0) return 1'b0;
        lim = longint'(1) << tid_bits;
        return (longint'(tid_base) + longint'(n_ch) - 1) < lim;
    endfunction

endpackage

// File: rtl/cyt_tid_stream_mux_skid_buf.sv
// Two-entry AXI-Stream register slice; ready depends only on the
// registered occupancy so no combinational path runs back upstream.
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign s_ready = (count != 2'd2);
    assign m_valid = (count != 2'd0);
    assign m_data  = head;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= s_data;
                    else tail <= s_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; the new beat lands behind whatever stays
                    if (count == 2'd1) begin
                        head <= s_data;
                    end else begin
                        head <= tail;
                        tail <= s_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/cyt_tid_stream_mux.sv
// Packet-granular round-robin merge of N ACCL send streams onto one
// Coyote send stream, stamping tid with the source channel.
module cyt_tid_stream_mux
    import cyt_mux_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int DATA_BITS = 512,
    parameter int TID_BITS  = 6,
    parameter int TID_BASE  = 0,
    localparam int CH_W     = ch_bits(N_CH),
    localparam int KEEP_W   = DATA_BITS / 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [N_CH*DATA_BITS-1:0] s_tdata,
    input  logic [N_CH*KEEP_W-1:0]    s_tkeep,
    input  logic [N_CH-1:0]           s_tlast,
    input  logic [N_CH-1:0]           s_tvalid,
    output logic [N_CH-1:0]           s_tready,
    output logic [DATA_BITS-1:0]      m_tdata,
    output logic [KEEP_W-1:0]         m_tkeep,
    output logic                      m_tlast,
    output logic [TID_BITS-1:0]       m_tid,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [CH_W-1:0]           active_ch,
    output logic                      busy
);

    localparam int PW = DATA_BITS + KEEP_W + 1 + TID_BITS;

    generate
        if (!params_ok(N_CH, TID_BITS, TID_BASE)) begin : g_bad_params
            $error("cyt_tid_stream_mux: illegal N_CH/TID_BITS/TID_BASE");
        end
    endgenerate

    logic [0:0]      state;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] winner;
    logic            found;
    logic [CH_W-1:0] sel;
    logic            sel_ok;
    logic            push_valid;
    logic            push_ready;
    logic            push_last;
    logic            accept;
    logic [PW-1:0]   push_data;
    logic [PW-1:0]   out_data;

    // first requester strictly after the last granted channel, with wrap
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!found && s_tvalid[(int'(rr_ptr) + k) % N_CH]) begin
                found  = 1'b1;
                winner = CH_W'((int'(rr_ptr) + k) % N_CH);
            end
        end
    end

    assign sel        = (state == ST_LOCK) ? active_ch : winner;
    assign sel_ok     = (state == ST_LOCK) | found;
    assign push_valid = sel_ok & s_tvalid[sel] & ~areset;
    assign push_last  = s_tlast[sel];
    assign accept     = push_valid & push_ready;
    assign busy       = (state == ST_LOCK);

    assign push_data = {
        s_tdata[int'(sel)*DATA_BITS +: DATA_BITS],
        s_tkeep[int'(sel)*KEEP_W +: KEEP_W],
        push_last,
        TID_BITS'(tid_of(TID_BASE, int'(sel)))
    };

    always_comb begin
        s_tready = '0;
        if (sel_ok && push_ready && !areset) s_tready[sel] = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= ST_IDLE;
            rr_ptr    <= CH_W'(N_CH - 1);
            active_ch <= '0;
        end else if (accept) begin
            unique case (state)
                ST_IDLE: begin
                    if (push_last) begin
                        rr_ptr <= winner;
                    end else begin
                        state     <= ST_LOCK;
                        active_ch <= winner;
                    end
                end
                ST_LOCK: begin
                    if (push_last) begin
                        state     <= ST_IDLE;
                        rr_ptr    <= active_ch;
                        active_ch <= '0;
                    end
                end
            endcase
        end
    end

    axis_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk     (aclk),
        .rst     (areset),
        .s_data  (push_data),
        .s_valid (push_valid),
        .s_ready (push_ready),
        .m_data  (out_data),
        .m_valid (m_tvalid),
        .m_ready (m_tready)
    );

    assign {m_tdata, m_tkeep, m_tlast, m_tid} = out_data;

endmodule

// File: tb/tb_cyt_tid_stream_mux.sv
// Bench for cyt_tid_stream_mux: directed scenarios plus a random phase,
// checked each cycle against a packet-level arbitration/FIFO model.
module tb_cyt_tid_stream_mux;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int TW  = 6;
    localparam int TB  = 0;
    localparam int AW  = 2;

    logic            clk = 1'b0;
    logic            areset = 1'b1;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N*KW-1:0] s_tkeep = '0;
    logic [N-1:0]    s_tlast = '0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [TW-1:0]   m_tid;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic [AW-1:0]   active_ch;
    logic            busy;

    always #5 clk = ~clk;

    cyt_tid_stream_mux #(
        .N_CH      (N),
        .DATA_BITS (DW),
        .TID_BITS  (TW),
        .TID_BASE  (TB)
    ) dut (
        .aclk      (clk),
        .areset    (areset),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tid     (m_tid),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .active_ch (active_ch),
        .busy      (busy)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct {
        int    ch;
        beat_t b;
    } ent_t;

    beat_t src_q [N][$];
    ent_t  out_q [$];
    int    grants [$];
    int    exp_g [$];
    int    gap [N];
    bit    hs_s [N];
    int    locked, last_g, vprob, tmode, full_cnt;
    int    delivered, tests, failed, cyc, d0, nb;
    bit    was_stall;
    logic [63:0] prev_m;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int ch, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = $urandom;
            b.k = KW'($urandom);
            b.l = (i == len - 1);
            src_q[ch].push_back(b);
        end
    endtask

    function automatic bit pending();
        bit p = (out_q.size() != 0) || (s_tvalid != '0);
        for (int c = 0; c < N; c++) if (src_q[c].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive(input bit adv);
        for (int c = 0; c < N; c++) begin
            if (hs_s[c]) begin
                void'(src_q[c].pop_front());
                s_tvalid[c] = 1'b0;
                hs_s[c] = 1'b0;
            end
            if (!s_tvalid[c]) begin
                if (gap[c] > 0) begin
                    if (adv) gap[c]--;
                end else if (src_q[c].size() != 0 &&
                             $urandom_range(99) < vprob) begin
                    s_tvalid[c] = 1'b1;
                    s_tdata[c*DW +: DW] = src_q[c][0].d;
                    s_tkeep[c*KW +: KW] = src_q[c][0].k;
                    s_tlast[c] = src_q[c][0].l;
                end
            end
        end
        if (adv) begin
            case (tmode)
                0: m_tready = 1'b1;
                1: m_tready = ~m_tready;
                2: m_tready = 1'($urandom_range(1));
                default: m_tready = 1'b0;
            endcase
        end
    endtask

    // one clock: check outputs against the model, then apply handshakes
    task automatic cycle();
        logic [N-1:0] er;
        ent_t e;
        bit f;
        int w;
        @(negedge clk);
        er = '0;
        if (out_q.size() < 2) begin
            if (locked >= 0) begin
                er[locked] = 1'b1;
            end else begin
                f = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    w = (last_g + i) % N;
                    if (!f && s_tvalid[w]) begin
                        f = 1'b1;
                        er[w] = 1'b1;
                    end
                end
            end
        end
        check("s_tready", s_tready, er);
        check("m_tvalid", m_tvalid, out_q.size() != 0);
        check("busy", busy, locked >= 0);
        check("active_ch", active_ch, (locked >= 0) ? locked : 0);
        if (out_q.size() != 0) begin
            e = out_q[0];
            check("m_tdata", m_tdata, e.b.d);
            check("m_tkeep", m_tkeep, e.b.k);
            check("m_tlast", m_tlast, e.b.l);
            check("m_tid", m_tid, e.ch + TB);
        end
        if (was_stall) check("m_stable", {m_tdata, m_tkeep, m_tlast, m_tid}, prev_m);
        was_stall = m_tvalid && !m_tready;
        prev_m = {m_tdata, m_tkeep, m_tlast, m_tid};
        if (out_q.size() == 2) full_cnt++;
        if (m_tvalid && m_tready && out_q.size() != 0) begin
            void'(out_q.pop_front());
            delivered++;
        end
        for (int c = 0; c < N; c++) begin
            if (s_tvalid[c] && s_tready[c]) begin
                e.ch = c;
                e.b = src_q[c][0];
                out_q.push_back(e);
                hs_s[c] = 1'b1;
                if (locked < 0) begin
                    grants.push_back(c);
                    if (!e.b.l) locked = c;
                    else last_g = c;
                end else if (e.b.l) begin
                    locked = -1;
                    last_g = c;
                end
            end
        end
        @(posedge clk);
        #1;
        drive(1'b1);
    endtask

    task automatic run(input int budget, output int n);
        n = 0;
        drive(1'b0);
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        if (pending()) begin
            tests++;
            failed++;
            $error("FAIL drain_timeout: observed %0d cycles required drain", n);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tkeep", m_tkeep, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tid", m_tid, 0);
        check("rst_busy", busy, 0);
        check("rst_active_ch", active_ch, 0);
        check("rst_s_tready", s_tready, 0);
        for (int c = 0; c < N; c++) begin
            src_q[c].delete();
            gap[c] = 0;
            hs_s[c] = 1'b0;
        end
        s_tvalid = '0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = '0;
        out_q.delete();
        grants.delete();
        locked = -1;
        last_g = N - 1;
        full_cnt = 0;
        was_stall = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    task automatic check_grants(input string tag);
        check({tag, "_grant_cnt"}, grants.size(), exp_g.size());
        foreach (exp_g[i]) begin
            if (i < grants.size()) check({tag, "_grant"}, grants[i], exp_g[i]);
        end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        delivered = 0;
        vprob = 100;
        tmode = 0;
        locked = -1;
        last_g = N - 1;
        was_stall = 1'b0;
        prev_m = '0;
        do_reset();

        // 3-beat packet on ch2: one cycle latency, one beat per cycle
        add_pkt(2, 3);
        run(200, cyc);
        check("t1_cycles", cyc, 4);
        exp_g = {2};
        check_grants("t1");

        // ch0 and ch2 together: whole ch0 packet, then ch2, no bubble
        do_reset();
        add_pkt(0, 4);
        add_pkt(2, 4);
        run(200, cyc);
        check("t2_cycles", cyc, 9);
        exp_g = {0, 2};
        check_grants("t2");

        // all channels single-beat packets: strict rotation at full rate
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < N; c++) add_pkt(c, 1);
        run(200, cyc);
        check("t3_cycles", cyc, 13);
        exp_g.delete();
        for (int i = 0; i < 3 * N; i++) exp_g.push_back(i % N);
        check_grants("t3");

        // locked ch1 gaps for 3 cycles while ch0 waits
        do_reset();
        add_pkt(1, 4);
        drive(1'b0);
        cycle();
        gap[1] = 3;
        add_pkt(0, 2);
        run(200, cyc);
        check("t4_cycles", cyc, 9);
        exp_g = {1, 0};
        check_grants("t4");

        // alternating m_tready over a 16-beat packet
        do_reset();
        tmode = 1;
        m_tready = 1'b1;
        d0 = delivered;
        add_pkt(0, 16);
        run(400, cyc);
        check("t5_beats", delivered - d0, 16);
        check("t5_full_seen", full_cnt > 0, 1);
        exp_g = {0};
        check_grants("t5");
        tmode = 0;
        m_tready = 1'b1;

        // reset mid-packet on ch3 with two beats buffered
        do_reset();
        tmode = 3;
        m_tready = 1'b0;
        add_pkt(3, 8);
        drive(1'b0);
        cycle();
        cycle();
        cycle();
        check("t6_full", full_cnt > 0, 1);
        do_reset();
        tmode = 0;
        m_tready = 1'b1;
        add_pkt(3, 2);
        add_pkt(0, 1);
        run(200, cyc);
        exp_g = {0, 3};
        check_grants("t6");

        // random traffic, random valid gaps and backpressure
        do_reset();
        vprob = 60;
        tmode = 2;
        d0 = delivered;
        nb = 0;
        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(5, 1);
            add_pkt($urandom_range(N - 1), len);
            nb += len;
        end
        run(5000, cyc);
        check("rand_beats", delivered - d0, nb);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
